rx_frame_assembler: RTL and testbench

//   Downstream of the Hamming-corrected transmission channel. Consumes one corrected byte

---
 rtl/rx_frame_pkg.sv | 20 ++
 rtl/rx_sync_fifo.sv | 63 ++++++
 rtl/rx_frame_assembler.sv | 176 +++++++++++++++++
 tb/tb_rx_frame_assembler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types for the receive frame assembler: FSM states and the FIFO entry layout.
package rx_frame_pkg;

  // Width of one stored FIFO entry: {sof, eof, frame_err, data[7:0]}.
  localparam int ENTRY_W = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       frame_err;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is read combinationally
// and driven to zero while empty. Pointers wrap naturally (DEPTH is a power of two);
// the occupancy count has one extra bit so that "full" is representable.
module rx_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  // A push into a full FIFO is still legal when a pop frees the slot in the same cycle.
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !w_empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/rx_frame_assembler.sv
// Groups corrected channel bytes into fixed-length frames and streams them out of a
// small FIFO with SOF/EOF markers and a per-frame error flag. A frame is admitted
// only if the FIFO has room for all of it at its first byte; otherwise it is dropped whole.
// Optional feature: define RX_FRAME_ERR_STATS_EN to build the saturating err_total counter.
//
// Output handshake: an entry transfers on every posedge where out_valid && out_ready;
// out_valid never depends on out_ready, and out_* hold while out_valid && !out_ready.
module rx_frame_assembler
  import rx_frame_pkg::*;
#(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_err,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_frame_err,
  output logic [7:0]       drop_cnt,
  output logic [CNT_W-1:0] err_total,
  output state_t           dbg_state
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          PW       = $clog2(FRAME_LEN);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] FLEN_C   = (AW+1)'(FRAME_LEN);
  localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LEN - 1);

  state_t          r_state;
  state_t          w_state_nx;
  logic [PW-1:0]   r_pos;
  logic [PW-1:0]   w_pos_nx;
  logic            r_acc;
  logic            w_acc_nx;
  logic [7:0]      r_drop_cnt;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  fifo_entry_t     w_entry;
  fifo_entry_t     w_head;
  logic [ENTRY_W-1:0] w_rd_data;
  logic            w_full;
  logic            w_empty;
  logic [AW:0]     w_count;
  logic [AW:0]     w_free;

  rx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (w_entry),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Free space seen at a frame start; pops this cycle are not counted as free yet.
  assign w_free = w_full ? '0 : (DEPTH_C - w_count);
  assign w_pop  = !w_empty && out_ready;

  // FSM state, byte position and running frame-error accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pos   <= w_pos_nx;
      r_acc   <= w_acc_nx;
    end
  end

  // Next-state, push decision and entry formatting; nothing moves without in_valid.
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_acc_nx   = r_acc;
    w_push     = 1'b0;
    w_drop     = 1'b0;
    w_entry    = '0;
    if (in_valid) begin
      case (r_state)
        IDLE: begin
          if (w_free >= FLEN_C) begin
            w_push       = 1'b1;
            w_entry.sof  = 1'b1;
            w_entry.data = in_data;
            w_acc_nx     = in_err;
            w_state_nx   = COLLECT;
          end else begin
            w_drop     = 1'b1;
            w_state_nx = DROP;
          end
          w_pos_nx = PW'(1);
        end
        COLLECT: begin
          w_push       = 1'b1;
          w_entry.data = in_data;
          if (r_pos == LAST_POS) begin
            w_entry.eof       = 1'b1;
            w_entry.frame_err = r_acc | in_err;
            w_state_nx        = IDLE;
            w_pos_nx          = '0;
            w_acc_nx          = 1'b0;
          end else begin
            w_pos_nx = r_pos + 1'b1;
            w_acc_nx = r_acc | in_err;
          end
        end
        DROP: begin
          if (r_pos == LAST_POS) begin
            w_state_nx = IDLE;
            w_pos_nx   = '0;
          end else begin
            w_pos_nx = r_pos + 1'b1;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_pos_nx   = '0;
          w_acc_nx   = 1'b0;
        end
      endcase
    end
  end

  // Saturating count of whole frames dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

`ifdef RX_FRAME_ERR_STATS_EN
  logic [CNT_W-1:0] r_err_total;

  // Saturating count of every valid byte flagged in_err, regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_total <= '0;
    end else if (in_valid && in_err && (r_err_total != {CNT_W{1'b1}})) begin
      r_err_total <= r_err_total + 1'b1;
    end
  end

  assign err_total = r_err_total;
`else
  assign err_total = '0;
`endif

  assign w_head        = w_rd_data;
  assign out_valid     = !w_empty;
  assign out_data      = w_head.data;
  assign out_sof       = w_head.sof;
  assign out_eof       = w_head.eof;
  assign out_frame_err = w_head.frame_err;
  assign drop_cnt      = r_drop_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler (FRAME_LEN=4, FIFO_DEPTH=8, CNT_W=2).
module tb_rx_frame_assembler;
  import rx_frame_pkg::*;

  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 2;

`ifdef RX_FRAME_ERR_STATS_EN
  localparam logic [CNT_W-1:0] EXP_ERR_TWO = 2'd2;
  localparam logic [CNT_W-1:0] EXP_ERR_SAT = 2'd3;
`else
  localparam logic [CNT_W-1:0] EXP_ERR_TWO = 2'd0;
  localparam logic [CNT_W-1:0] EXP_ERR_SAT = 2'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic [7:0]       in_data   = 8'h00;
  logic             in_err    = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_sof;
  logic             out_eof;
  logic             out_frame_err;
  logic [7:0]       drop_cnt;
  logic [CNT_W-1:0] err_total;
  state_t           dbg_state;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  rx_frame_assembler #(
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_err        (in_err),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_frame_err (out_frame_err),
    .drop_cnt      (drop_cnt),
    .err_total     (err_total),
    .dbg_state     (dbg_state)
  );

  // Capture every accepted output entry; inputs only change 1ns after posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back({out_sof, out_eof, out_frame_err, out_data});
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  function automatic logic [10:0] ent(input logic s, input logic e, input logic f,
                                      input logic [7:0] d);
    return {s, e, f, d};
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic e);
    in_valid = 1'b1;
    in_data  = d;
    in_err   = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_err    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if ({out_sof, out_eof, out_frame_err} !== 3'b000) begin errors++; $display("FAIL reset_markers got %b exp 000", {out_sof, out_eof, out_frame_err}); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    checks++; if (err_total !== '0) begin errors++; $display("FAIL reset_err_total got %0d exp 0", err_total); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    apply_reset();
    out_ready = 1'b1;
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 8'h11));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h22));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h33));
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h44));
    send_byte(8'h11, 1'b0);
    // One-cycle latency through an empty FIFO.
    checks++; if ({out_valid, out_sof, out_data} !== {1'b1, 1'b1, 8'h11}) begin errors++; $display("FAIL basic_first_visible got %b/%b/%h exp 1/1/11", out_valid, out_sof, out_data); end
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    idle_cycles(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_entry%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame_err();
    apply_reset();
    out_ready = 1'b1;
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 8'hAA));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'hBB));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'hCC));
    exp_q.push_back(ent(1'b0, 1'b1, 1'b1, 8'hDD));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 8'h01));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h02));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h03));
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h04));
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    idle_cycles(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ferr_entry%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure_drop();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i), 1'b0);
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop_cnt got %0d exp 1", drop_cnt); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL bp_state got %0d exp %0d", dbg_state, IDLE); end
    checks++; if ({out_valid, out_sof, out_eof, out_data} !== {3'b110, 8'h20}) begin errors++; $display("FAIL bp_head got %b%b%b/%h exp 110/20", out_valid, out_sof, out_eof, out_data); end
    idle_cycles(3);
    checks++; if ({out_valid, out_sof, out_eof, out_data} !== {3'b110, 8'h20}) begin errors++; $display("FAIL bp_hold got %b%b%b/%h exp 110/20", out_valid, out_sof, out_eof, out_data); end
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(ent(b == 0, b == 3, 1'b0, 8'h20 + 8'(f * 4 + b)));
    out_ready = 1'b1;
    idle_cycles(12);
    out_ready = 1'b0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_entry%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_full_pop_start();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b0);
    // Full FIFO: pop and frame start on the same cycle -> frame is dropped.
    out_ready = 1'b1;
    send_byte(8'h40, 1'b0);
    checks++; if (dbg_state !== DROP) begin errors++; $display("FAIL full_state_drop got %0d exp %0d", dbg_state, DROP); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_drop_cnt got %0d exp 1", drop_cnt); end
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b0);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL full_state_idle got %0d exp %0d", dbg_state, IDLE); end
    // Four pops later there are exactly FRAME_LEN free entries -> accepted.
    send_byte(8'h50, 1'b0);
    checks++; if (dbg_state !== COLLECT) begin errors++; $display("FAIL full_state_collect got %0d exp %0d", dbg_state, COLLECT); end
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h53, 1'b0);
    idle_cycles(8);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(ent((i % 4) == 0, (i % 4) == 3, 1'b0, 8'h30 + 8'(i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(i == 0, i == 3, 1'b0, 8'h50 + 8'(i)));
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_drop_cnt_end got %0d exp 1", drop_cnt); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_entry%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    out_ready = 1'b0;
    send_byte(8'h60, 1'b0);
    send_byte(8'h61, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_sof, out_eof, out_frame_err, out_data} !== 12'h000) begin errors++; $display("FAIL mid_rst_outputs got %h exp 000", {out_valid, out_sof, out_eof, out_frame_err, out_data}); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_rst_state got %0d exp %0d", dbg_state, IDLE); end
    checks++; if (err_total !== '0) begin errors++; $display("FAIL mid_rst_err_total got %0d exp 0", err_total); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ent(i == 0, i == 3, 1'b0, 8'h70 + 8'(i)));
      send_byte(8'h70 + 8'(i), 1'b0);
    end
    idle_cycles(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_entry%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_err_stats();
    apply_reset();
    out_ready = 1'b1;
    send_byte(8'h80, 1'b1);
    send_byte(8'h81, 1'b1);
    checks++; if (err_total !== EXP_ERR_TWO) begin errors++; $display("FAIL stats_two got %0d exp %0d", err_total, EXP_ERR_TWO); end
    send_byte(8'h82, 1'b1);
    send_byte(8'h83, 1'b1);
    send_byte(8'h84, 1'b1);
    send_byte(8'h85, 1'b0);
    send_byte(8'h86, 1'b0);
    send_byte(8'h87, 1'b0);
    idle_cycles(4);
    checks++; if (err_total !== EXP_ERR_SAT) begin errors++; $display("FAIL stats_sat got %0d exp %0d", err_total, EXP_ERR_SAT); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stats_count got %0d exp 8", got_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_frame_err();
    test_backpressure_drop();
    test_full_pop_start();
    test_reset_midframe();
    test_err_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
